// File: rtl/status_led_if.sv
// Signal bundle between the CPU status flags and the RGB LED PWM pins.
// The master side drives the CPU flags and watches the LEDs; the LED block is the slave.
interface status_led_if;
    logic       i_running;
    logic       i_status;
    logic       o_led_r;
    logic       o_led_g;
    logic       o_led_b;
    logic [1:0] o_state;

    modport master (
        output i_running,
        output i_status,
        input  o_led_r,
        input  o_led_g,
        input  o_led_b,
        input  o_state
    );

    modport slave (
        input  i_running,
        input  i_status,
        output o_led_r,
        output o_led_g,
        output o_led_b,
        output o_state
    );
endinterface

// File: rtl/status_led.sv
// Registered RGB status indication for the CPU test bench.
// Blue breathes while the CPU runs, green is solid on pass, red blinks on fail.
// The flags are registered once, the FSM runs on the registered copies, and
// each LED output is a registered PWM compare, so LEDs trail o_state by one clock.
module status_led #(
    parameter int TICK_DIV    = 46875,
    parameter int PWM_BITS    = 8,
    parameter int PASS_DUTY   = 128,
    parameter int FAIL_DUTY   = 255,
    parameter int BLINK_TICKS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    status_led_if.slave bus
);
    localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] BRIGHT_MAX  = '1;
    localparam logic [PWM_BITS-1:0] BRIGHT_NEAR = BRIGHT_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] BRIGHT_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] PASS_D      = PWM_BITS'(PASS_DUTY);
    localparam logic [PWM_BITS-1:0] FAIL_D      = PWM_BITS'(FAIL_DUTY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 r_running_q, r_status_q;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic                 tick;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [PWM_BITS-1:0]  bright_q, bright_d;
    logic                 dir_down_q, dir_down_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 phase_off_q, phase_off_d;
    logic                 led_r_q, led_g_q, led_b_q;
    logic                 led_r_d, led_g_d, led_b_d;

    // An LED is lit while the free-running PWM count is below its duty.
    function automatic logic pwm_on(input logic [PWM_BITS-1:0] cnt,
                                    input logic [PWM_BITS-1:0] duty);
        return cnt < duty;
    endfunction

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Next state from the registered flags; pass/fail only after a run was seen.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (r_running_q) state_d = S_RUN;
            S_RUN:   if (!r_running_q) state_d = r_status_q ? S_PASS : S_FAIL;
            default: if (r_running_q) state_d = S_RUN;
        endcase
    end

    // Triangle brightness: restart at 0 on RUN entry, turn around at both ends.
    always_comb begin
        bright_d   = bright_q;
        dir_down_d = dir_down_q;
        if (state_d == S_RUN && state_q != S_RUN) begin
            bright_d   = '0;
            dir_down_d = 1'b0;
        end else if (state_q == S_RUN && tick) begin
            if (!dir_down_q) begin
                bright_d = bright_q + 1'b1;
                if (bright_q == BRIGHT_NEAR) dir_down_d = 1'b1;
            end else begin
                bright_d = bright_q - 1'b1;
                if (bright_q == BRIGHT_ONE) dir_down_d = 1'b0;
            end
        end
    end

    // Blink timer: starts in the on phase when FAIL is entered.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_off_d = phase_off_q;
        if (state_d == S_FAIL && state_q != S_FAIL) begin
            blink_cnt_d = '0;
            phase_off_d = 1'b0;
        end else if (state_q == S_FAIL && tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_off_d = ~phase_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // LED selection by current state; only one colour can ever be enabled.
    always_comb begin
        led_r_d = (state_q == S_FAIL) && !phase_off_q && pwm_on(pwm_cnt_q, FAIL_D);
        led_g_d = (state_q == S_PASS) && pwm_on(pwm_cnt_q, PASS_D);
        led_b_d = (state_q == S_RUN)  && pwm_on(pwm_cnt_q, bright_q);
    end

    // All state, counters and outputs, cleared by the synchronous reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            r_running_q <= 1'b0;
            r_status_q  <= 1'b0;
            tick_cnt_q  <= '0;
            pwm_cnt_q   <= '0;
            bright_q    <= '0;
            dir_down_q  <= 1'b0;
            blink_cnt_q <= '0;
            phase_off_q <= 1'b0;
            led_r_q     <= 1'b0;
            led_g_q     <= 1'b0;
            led_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_running_q <= bus.i_running;
            r_status_q  <= bus.i_status;
            tick_cnt_q  <= tick_cnt_d;
            pwm_cnt_q   <= pwm_cnt_q + 1'b1;
            bright_q    <= bright_d;
            dir_down_q  <= dir_down_d;
            blink_cnt_q <= blink_cnt_d;
            phase_off_q <= phase_off_d;
            led_r_q     <= led_r_d;
            led_g_q     <= led_g_d;
            led_b_q     <= led_b_d;
        end
    end

    assign bus.o_state = state_q;
    assign bus.o_led_r = led_r_q;
    assign bus.o_led_g = led_g_q;
    assign bus.o_led_b = led_b_q;
endmodule

// File: tb/tb_status_led.sv
// Bench for status_led with small parameters (4-clock tick, 4-bit PWM, 3-tick blink).
// A reference model pushes the expected {state,r,g,b} after every clock edge;
// the entry is popped on the following falling edge and compared by each scenario task.
module tb_status_led;
    localparam int TD   = 4;
    localparam int PB   = 4;
    localparam int PD   = 8;
    localparam int FD   = 15;
    localparam int BT   = 3;
    localparam int MAXB = (1 << PB) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    status_led_if bus();

    status_led #(
        .TICK_DIV(TD), .PWM_BITS(PB), .PASS_DUTY(PD), .FAIL_DUTY(FD), .BLINK_TICKS(BT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       r;
        logic       g;
        logic       b;
    } exp_t;

    exp_t sb[$];
    exp_t exp_cur = '0;
    int   tests = 0;
    int   fails = 0;

    // Model state: edges since reset, entry edge of the current state, registered flags.
    int         m_k     = 0;
    int         m_es    = 0;
    logic [1:0] m_state = 2'd0;
    logic       m_rrun  = 1'b0;
    logic       m_rstat = 1'b0;

    function automatic logic [1:0] f_next(input logic [1:0] s, input logic run, input logic pass);
        case (s)
            2'd0:    return run ? 2'd1 : 2'd0;
            2'd1:    return run ? 2'd1 : (pass ? 2'd2 : 2'd3);
            default: return run ? 2'd1 : s;
        endcase
    endfunction

    // {r,g,b} registered at the edge after edge kold, given state s entered at edge es.
    function automatic logic [2:0] f_leds(input logic [1:0] s, input int kold, input int es);
        int n, p, br, pwm;
        pwm = kold % (MAXB + 1);
        n   = kold / TD - es / TD;
        case (s)
            2'd1: begin
                p  = n % (2 * MAXB);
                br = (p <= MAXB) ? p : 2 * MAXB - p;
                return {2'b00, pwm < br};
            end
            2'd2:    return {1'b0, pwm < PD, 1'b0};
            2'd3:    return {((n / BT) % 2 == 0) && (pwm < FD), 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_k     <= 0;
            m_es    <= 0;
            m_state <= 2'd0;
            m_rrun  <= 1'b0;
            m_rstat <= 1'b0;
            sb.push_back(5'b0);
        end else begin
            sb.push_back({f_next(m_state, m_rrun, m_rstat), f_leds(m_state, m_k, m_es)});
            if (f_next(m_state, m_rrun, m_rstat) != m_state) m_es <= m_k + 1;
            m_state <= f_next(m_state, m_rrun, m_rstat);
            m_k     <= m_k + 1;
            m_rrun  <= bus.i_running;
            m_rstat <= bus.i_status;
        end
    end

    always @(negedge clk) begin
        if (sb.size() != 0) exp_cur <= sb.pop_front();
    end

    task automatic tick1();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_running = 1'b1;
        bus.i_status  = 1'b0;
        repeat (5) begin
            tick1();
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== 5'b0) begin
                fails++;
                $display("FAIL reset_hold got %b required 00000",
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b});
            end
        end
        rst_n = 1'b1;
        tick1();
        tests++;
        if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== exp_cur) begin
            fails++;
            $display("FAIL release_e1 got %b required %b",
                     {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b}, exp_cur);
        end
        tick1();
        tests++;
        if (bus.o_state !== 2'd1 || bus.o_led_b !== 1'b0) begin
            fails++;
            $display("FAIL release_e2 got state=%0d b=%b required state=1 b=0",
                     bus.o_state, bus.o_led_b);
        end
    endtask

    task automatic test_breathing();
        int peak = 0;
        int trough = 0;
        while (m_k < 130) begin
            tick1();
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== exp_cur) begin
                fails++;
                $display("FAIL breathe k=%0d got %b required %b", m_k,
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b}, exp_cur);
            end
            if (m_k >= 61 && m_k <= 64)   peak   += int'(bus.o_led_b);
            if (m_k >= 121 && m_k <= 124) trough += int'(bus.o_led_b);
        end
        tests++;
        if (peak != 3) begin
            fails++;
            $display("FAIL breathe_peak high=%0d required 3", peak);
        end
        tests++;
        if (trough != 0) begin
            fails++;
            $display("FAIL breathe_trough high=%0d required 0", trough);
        end
    endtask

    task automatic test_pass();
        int gcnt = 0;
        bus.i_running = 1'b0;
        bus.i_status  = 1'b1;
        tick1();
        tests++;
        if (bus.o_state !== 2'd1) begin
            fails++;
            $display("FAIL pass_latency got state=%0d required 1", bus.o_state);
        end
        tick1();
        tests++;
        if (bus.o_state !== 2'd2) begin
            fails++;
            $display("FAIL pass_state got state=%0d required 2", bus.o_state);
        end
        repeat (2) tick1();
        repeat (16) begin
            tick1();
            gcnt += int'(bus.o_led_g);
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== exp_cur) begin
                fails++;
                $display("FAIL pass k=%0d got %b required %b", m_k,
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b}, exp_cur);
            end
        end
        tests++;
        if (gcnt != PD) begin
            fails++;
            $display("FAIL pass_duty high=%0d required %0d", gcnt, PD);
        end
    endtask

    task automatic test_fail_blink();
        bus.i_running = 1'b1;
        repeat (6) tick1();
        bus.i_running = 1'b0;
        bus.i_status  = 1'b0;
        repeat (2) tick1();
        tests++;
        if (bus.o_state !== 2'd3) begin
            fails++;
            $display("FAIL fail_state got state=%0d required 3", bus.o_state);
        end
        for (int i = 0; i < 60; i++) begin
            if (i % 7 == 6) bus.i_status = ~bus.i_status;
            tick1();
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== exp_cur) begin
                fails++;
                $display("FAIL blink k=%0d got %b required %b", m_k,
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b}, exp_cur);
            end
        end
        tests++;
        if (bus.o_state !== 2'd3) begin
            fails++;
            $display("FAIL fail_sticky got state=%0d required 3", bus.o_state);
        end
    endtask

    task automatic test_rerun_reset();
        bus.i_running = 1'b1;
        repeat (2) tick1();
        tests++;
        if (bus.o_state !== 2'd1) begin
            fails++;
            $display("FAIL rerun_state got state=%0d required 1", bus.o_state);
        end
        repeat (20) begin
            tick1();
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== exp_cur) begin
                fails++;
                $display("FAIL rerun k=%0d got %b required %b", m_k,
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b}, exp_cur);
            end
        end
        rst_n = 1'b0;
        tick1();
        tests++;
        if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== 5'b0) begin
            fails++;
            $display("FAIL midrun_reset got %b required 00000",
                     {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b});
        end
        rst_n = 1'b1;
        repeat (40) begin
            tick1();
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== exp_cur) begin
                fails++;
                $display("FAIL post_reset k=%0d got %b required %b", m_k,
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b}, exp_cur);
            end
        end
    endtask

    task automatic test_no_run();
        rst_n = 1'b0;
        bus.i_running = 1'b0;
        bus.i_status  = 1'b0;
        repeat (2) tick1();
        rst_n = 1'b1;
        repeat (100) begin
            bus.i_status = ~bus.i_status;
            tick1();
            tests++;
            if ({bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b} !== 5'b0) begin
                fails++;
                $display("FAIL no_run got %b required 00000",
                         {bus.o_state, bus.o_led_r, bus.o_led_g, bus.o_led_b});
            end
        end
    endtask

    initial begin
        bus.i_running = 1'b1;
        bus.i_status  = 1'b0;
        test_reset();
        test_breathing();
        test_pass();
        test_fail_blink();
        test_rerun_reset();
        test_no_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
